issue_ctrl: RTL and testbench

- Single-slot issue controller between decode and execute.
- Latches one decoded instruction and queries the register scoreboard for its source registers.
- Holds the instruction until both sources are clear, then issues it downstream with a valid/ready handshake.
- In the issue cycle, drives the destination register to the scoreboard so the scoreboard marks it busy.

---
 rtl/issue_ctrl.sv | 128 ++++++++++++
 tb/tb_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Single-slot issue controller between decode and execute.
// Holds one decoded instruction and queries the register scoreboard for its sources.
// It offers the instruction to execute once both sources are clear. In the issue cycle it
// marks the destination busy in the scoreboard.
// Optional feature: define ISSUE_STALL_CNT_EN to build the hazard-stall cycle counter.
module issue_ctrl #(
  parameter int unsigned RFADDR    = 5,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [RFADDR-1:0]    in_rs1_i,
  input  logic [RFADDR-1:0]    in_rs2_i,
  input  logic [RFADDR-1:0]    in_rd_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic [RFADDR-1:0]    sb_query_1_o,
  output logic [RFADDR-1:0]    sb_query_2_o,
  input  logic                 sb_busy_1_i,
  input  logic                 sb_busy_2_i,
  output logic [RFADDR-1:0]    sb_mark_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [RFADDR-1:0]    out_rd_o,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [31:0]          stall_cycles_o
);

  typedef enum logic [1:0] {StEmpty, StStall, StOffer} state_e;

  // Only slot occupancy is stored; STALL vs OFFER comes from the live scoreboard every cycle,
  // so a busy bit cleared at an edge wakes the slot in the very next cycle.
  logic                 r_valid;
  logic [RFADDR-1:0]    r_rs1;
  logic [RFADDR-1:0]    r_rs2;
  logic [RFADDR-1:0]    r_rd;
  logic [PAYLOAD_W-1:0] r_payload;

  state_e w_state;
  logic   w_hazard;
  logic   w_accept;
  logic   w_issue;
  logic   w_valid_d;

  // Decode the current state and drive the handshake, query and mark outputs.
  always_comb begin
    w_hazard     = sb_busy_1_i | sb_busy_2_i;
    w_state      = StEmpty;
    if (r_valid) begin
      w_state = w_hazard ? StStall : StOffer;
    end
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    sb_query_1_o = r_valid ? r_rs1 : '0;
    sb_query_2_o = r_valid ? r_rs2 : '0;
    unique case (w_state)
      StEmpty: in_ready_o = ~flush_i;
      StStall: in_ready_o = 1'b0;
      StOffer: begin
        out_valid_o = ~flush_i;
        in_ready_o  = ~flush_i & out_ready_i;
      end
      default: in_ready_o = 1'b0;
    endcase
    w_issue   = out_valid_o & out_ready_i;
    w_accept  = in_valid_i & in_ready_o;
    sb_mark_o = w_issue ? r_rd : '0;
  end

  // Next slot occupancy: flush beats accept, accept beats issue (back-to-back refill).
  always_comb begin
    w_valid_d = r_valid;
    if (flush_i) begin
      w_valid_d = 1'b0;
    end else if (w_accept) begin
      w_valid_d = 1'b1;
    end else if (w_issue) begin
      w_valid_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_valid_d;
    end
  end

  // Slot contents, captured only on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_payload <= '0;
    end else if (w_accept) begin
      r_rs1     <= in_rs1_i;
      r_rs2     <= in_rs2_i;
      r_rd      <= in_rd_i;
      r_payload <= in_payload_i;
    end
  end

  assign out_rd_o      = r_rd;
  assign out_payload_o = r_payload;

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count non-flush STALL cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if ((w_state == StStall) && !flush_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed testbench for issue_ctrl with a 32-entry scoreboard model.
module tb_issue_ctrl;

`ifdef ISSUE_STALL_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_rs1_i;
  logic [4:0]  in_rs2_i;
  logic [4:0]  in_rd_i;
  logic [63:0] in_payload_i;
  logic [4:0]  sb_query_1_o;
  logic [4:0]  sb_query_2_o;
  logic        sb_busy_1_i;
  logic        sb_busy_2_i;
  logic [4:0]  sb_mark_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  out_rd_o;
  logic [63:0] out_payload_o;
  logic [31:0] stall_cycles_o;

  logic [31:0] sb_busy;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign sb_busy_1_i = sb_busy[sb_query_1_o];
  assign sb_busy_2_i = sb_busy[sb_query_2_o];

  issue_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_rs1_i      (in_rs1_i),
    .in_rs2_i      (in_rs2_i),
    .in_rd_i       (in_rd_i),
    .in_payload_i  (in_payload_i),
    .sb_query_1_o  (sb_query_1_o),
    .sb_query_2_o  (sb_query_2_o),
    .sb_busy_1_i   (sb_busy_1_i),
    .sb_busy_2_i   (sb_busy_2_i),
    .sb_mark_o     (sb_mark_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_rd_o      (out_rd_o),
    .out_payload_o (out_payload_o),
    .stall_cycles_o(stall_cycles_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample the mark mid-cycle, apply it to the scoreboard model at the edge.
  task automatic cyc();
    logic [4:0] mark;
    @(negedge clk);
    mark = sb_mark_o;
    @(posedge clk);
    if (mark != 5'd0) sb_busy[mark] = 1'b1;
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [63:0] pl);
    in_valid_i   = v;
    in_rs1_i     = rs1;
    in_rs2_i     = rs2;
    in_rd_i      = rd;
    in_payload_i = pl;
  endtask

  initial begin
    reset_n     = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    sb_busy     = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0);
    #2;
    check_eq("rst_in_ready", in_ready_o, 1);
    check_eq("rst_out_valid", out_valid_o, 0);
    check_eq("rst_q1", sb_query_1_o, 0);
    check_eq("rst_q2", sb_query_2_o, 0);
    check_eq("rst_mark", sb_mark_o, 0);
    check_eq("rst_out_rd", out_rd_o, 0);
    check_eq("rst_payload", out_payload_o, 0);
    check_eq("rst_stall", stall_cycles_o, 0);
    #10 reset_n = 1'b1;
    cyc();

    // Simple issue: rs1=3 rs2=4 rd=5.
    drive(1'b1, 5'd3, 5'd4, 5'd5, 64'hA1A1);
    out_ready_i = 1'b1;
    #1 check_eq("t1_in_ready_acc", in_ready_o, 1);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check_eq("t1_out_valid", out_valid_o, 1);
    check_eq("t1_mark", sb_mark_o, 5);
    check_eq("t1_in_ready", in_ready_o, 1);
    check_eq("t1_q1", sb_query_1_o, 3);
    check_eq("t1_q2", sb_query_2_o, 4);
    check_eq("t1_payload", out_payload_o, 64'hA1A1);
    cyc();
    check_eq("t1_empty_valid", out_valid_o, 0);
    check_eq("t1_empty_q1", sb_query_1_o, 0);
    check_eq("t1_busy5_set", sb_busy[5], 1);

    // Stall on rs1=5 (busy from the previous issue) for 4 cycles.
    drive(1'b1, 5'd5, 5'd0, 5'd6, 64'hB2B2);
    cyc();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_stall_valid", out_valid_o, 0);
      check_eq("t2_stall_mark", sb_mark_o, 0);
      check_eq("t2_stall_in_ready", in_ready_o, 0);
      cyc();
    end
    sb_busy[5] = 1'b0;
    #1;
    check_eq("t2_wake_valid", out_valid_o, 1);
    check_eq("t2_wake_mark", sb_mark_o, 6);
    check_eq("t2_stall_cnt", stall_cycles_o, CntEn ? 4 : 0);
    cyc();

    // Back-to-back RAW: A writes 7, B reads 7.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 64'hAAAA);
    cyc();
    drive(1'b1, 5'd0, 5'd7, 5'd8, 64'hBBBB);
    #1;
    check_eq("t3_a_valid", out_valid_o, 1);
    check_eq("t3_a_mark", sb_mark_o, 7);
    check_eq("t3_a_in_ready", in_ready_o, 1);
    cyc();
    in_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("t3_b_q2", sb_query_2_o, 7);
      check_eq("t3_b_stall_valid", out_valid_o, 0);
      cyc();
    end
    sb_busy[7] = 1'b0;
    #1;
    check_eq("t3_b_valid", out_valid_o, 1);
    check_eq("t3_b_mark", sb_mark_o, 8);
    check_eq("t3_b_payload", out_payload_o, 64'hBBBB);
    check_eq("t3_stall_cnt", stall_cycles_o, CntEn ? 6 : 0);
    cyc();

    // OFFER held with out_ready_i=0 for 3 cycles; decode keeps offering D.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 64'hC3C3);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd10, 64'hD4D4);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_hold_valid", out_valid_o, 1);
      check_eq("t4_hold_payload", out_payload_o, 64'hC3C3);
      check_eq("t4_hold_rd", out_rd_o, 9);
      check_eq("t4_hold_in_ready", in_ready_o, 0);
      check_eq("t4_hold_mark", sb_mark_o, 0);
      cyc();
    end
    out_ready_i = 1'b1;
    #1;
    check_eq("t4_rel_mark", sb_mark_o, 9);
    check_eq("t4_rel_in_ready", in_ready_o, 1);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check_eq("t4_d_valid", out_valid_o, 1);
    check_eq("t4_d_rd", out_rd_o, 10);

    // Flush in OFFER with a new instruction offered.
    flush_i = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd11, 64'hE5E5);
    #1;
    check_eq("t5_fo_valid", out_valid_o, 0);
    check_eq("t5_fo_mark", sb_mark_o, 0);
    check_eq("t5_fo_in_ready", in_ready_o, 0);
    cyc();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check_eq("t5_fo_empty_valid", out_valid_o, 0);
    check_eq("t5_fo_empty_ready", in_ready_o, 1);
    check_eq("t5_fo_no_capture", sb_query_1_o, 0);
    check_eq("t5_fo_no_mark10", sb_busy[10], 0);

    // Flush in STALL.
    sb_busy[12] = 1'b1;
    drive(1'b1, 5'd12, 5'd0, 5'd13, 64'hF6F6);
    cyc();
    in_valid_i = 1'b0;
    #1 check_eq("t5_fs_stall_valid", out_valid_o, 0);
    cyc();
    flush_i = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd14, 64'h1717);
    #1;
    check_eq("t5_fs_mark", sb_mark_o, 0);
    check_eq("t5_fs_in_ready", in_ready_o, 0);
    cyc();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    sb_busy[12] = 1'b0;
    #1;
    check_eq("t5_fs_empty_ready", in_ready_o, 1);
    check_eq("t5_fs_empty_q1", sb_query_1_o, 0);
    check_eq("t5_fs_stall_cnt", stall_cycles_o, CntEn ? 7 : 0);

    // rd=0 issues without a mark.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 64'h2828);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check_eq("t6_rd0_valid", out_valid_o, 1);
    check_eq("t6_rd0_mark", sb_mark_o, 0);
    cyc();

    // Asynchronous reset mid-STALL.
    sb_busy[15] = 1'b1;
    drive(1'b1, 5'd15, 5'd0, 5'd16, 64'h3939);
    cyc();
    in_valid_i = 1'b0;
    #1 check_eq("t6_pre_rst_ready", in_ready_o, 0);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid_o, 0);
    check_eq("t6_rst_in_ready", in_ready_o, 1);
    check_eq("t6_rst_q1", sb_query_1_o, 0);
    check_eq("t6_rst_payload", out_payload_o, 0);
    check_eq("t6_rst_stall", stall_cycles_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
